// File: rtl/oled_spi_sink.sv
// oled_spi_sink: SSD1331-style OLED SPI receiver that assembles bytes, parses
// window commands and turns RGB565 pixel data into framebuffer write strobes.
//   clk, reset(async, active-low)   system clock / reset
//   sck, mosi, cs, dc               SPI mode-0 bus from the master (async to clk)
//   byte_valid, byte_data, byte_is_cmd  one-cycle strobe per received byte
//   wr_en, wr_addr, wr_data         one-cycle pixel write (row*COLS+col, RGB565)
//   frame_done                      strobe with the write of the window's last pixel
//   cmd_busy                        high while command arguments are still expected
module oled_spi_sink #(
   parameter int COLS        = 96,
   parameter int ROWS        = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sck,
   input  logic        mosi,
   input  logic        cs,
   input  logic        dc,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        byte_is_cmd,
   output logic        wr_en,
   output logic [12:0] wr_addr,
   output logic [15:0] wr_data,
   output logic        frame_done,
   output logic        cmd_busy
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

   typedef enum logic [2:0] {IDLE, COL_A, COL_B, ROW_A, ROW_B, SKIP} state_t;
   state_t state, state_nx;

   logic [SYNC_STAGES-1:0] sck_q, mosi_q, cs_q, dc_q;
   logic          sck_d, sck_s, mosi_s, cs_s, dc_s, rise, cmd, pix, phase;
   logic [6:0]    shreg;
   logic [2:0]    bit_cnt;
   logic [3:0]    skip_cnt;
   logic [7:0]    hi;
   logic [CW-1:0] col_start, col_end, col_ptr, col_tmp, col_arg, col_endv;
   logic [RW-1:0] row_start, row_end, row_ptr, row_tmp, row_arg, row_endv;

   assign sck_s  = sck_q[SYNC_STAGES-1];
   assign mosi_s = mosi_q[SYNC_STAGES-1];
   assign cs_s   = cs_q[SYNC_STAGES-1];
   assign dc_s   = dc_q[SYNC_STAGES-1];
   assign rise   = sck_s & ~sck_d;
   assign cmd    = byte_valid & byte_is_cmd;
   assign pix    = byte_valid & ~byte_is_cmd;

   // Arguments are clamped to the panel, and an end below its start collapses
   // onto the start so the window is never empty.
   assign col_arg  = (byte_data > 8'(COLS - 1)) ? COL_MAX : byte_data[CW-1:0];
   assign row_arg  = (byte_data > 8'(ROWS - 1)) ? ROW_MAX : byte_data[RW-1:0];
   assign col_endv = (col_arg < col_tmp) ? col_tmp : col_arg;
   assign row_endv = (row_arg < row_tmp) ? row_tmp : row_arg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sck_q  <= '0;
         mosi_q <= '0;
         cs_q   <= '0;
         dc_q   <= '0;
         sck_d  <= 1'b0;
      end else begin
         sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
         cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
         dc_q   <= {dc_q[SYNC_STAGES-2:0], dc};
         sck_d  <= sck_s;
      end
   end

   // Deselect drops any partial byte; only whole bytes reach the parser.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg       <= '0;
         bit_cnt     <= '0;
         byte_valid  <= 1'b0;
         byte_data   <= '0;
         byte_is_cmd <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (cs_s) begin
            bit_cnt <= '0;
         end else if (rise) begin
            shreg   <= {shreg[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_valid  <= 1'b1;
               byte_data   <= {shreg, mosi_s};
               byte_is_cmd <= ~dc_s;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // A pixel byte arriving mid-command abandons the command.
   always_comb begin
      state_nx = state;
      cmd_busy = (state != IDLE);
      if (pix) begin
         state_nx = IDLE;
      end else if (cmd) begin
         case (state)
            IDLE:    state_nx = (byte_data == 8'h15) ? COL_A :
                                (byte_data == 8'h75) ? ROW_A :
                                (byte_data inside {8'h21, 8'h22, 8'h25, 8'h26}) ? SKIP : IDLE;
            COL_A:   state_nx = COL_B;
            ROW_A:   state_nx = ROW_B;
            SKIP:    state_nx = (skip_cnt == 4'd1) ? IDLE : SKIP;
            default: state_nx = IDLE;
         endcase
      end
   end

   // The window start is held in a scratch register until the end argument
   // arrives, so an aborted command leaves the live window untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         skip_cnt   <= '0;
         col_tmp    <= '0;
         row_tmp    <= '0;
         col_start  <= '0;
         col_end    <= COL_MAX;
         col_ptr    <= '0;
         row_start  <= '0;
         row_end    <= ROW_MAX;
         row_ptr    <= '0;
         phase      <= 1'b0;
         hi         <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         if (cmd) begin
            case (state)
               IDLE:  skip_cnt <= (byte_data == 8'h21) ? 4'd7 :
                                  (byte_data == 8'h22) ? 4'd10 :
                                  (byte_data == 8'h25) ? 4'd4 : 4'd1;
               COL_A: col_tmp <= col_arg;
               COL_B: begin
                  col_start <= col_tmp;
                  col_end   <= col_endv;
                  col_ptr   <= col_tmp;
                  phase     <= 1'b0;
               end
               ROW_A: row_tmp <= row_arg;
               ROW_B: begin
                  row_start <= row_tmp;
                  row_end   <= row_endv;
                  row_ptr   <= row_tmp;
                  phase     <= 1'b0;
               end
               SKIP:  skip_cnt <= skip_cnt - 4'd1;
               default: ;
            endcase
         end
         if (pix) begin
            if (!phase) begin
               hi    <= byte_data;
               phase <= 1'b1;
            end else begin
               phase      <= 1'b0;
               wr_en      <= 1'b1;
               wr_data    <= {hi, byte_data};
               wr_addr    <= 13'(row_ptr) * 13'(COLS) + 13'(col_ptr);
               frame_done <= (col_ptr == col_end) && (row_ptr == row_end);
               col_ptr    <= (col_ptr == col_end) ? col_start : col_ptr + 1'b1;
               if (col_ptr == col_end) row_ptr <= (row_ptr == row_end) ? row_start : row_ptr + 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/oled_spi_sink.md
Name: oled_spi_sink

Overview:
- Receiving end of the OLED SPI link: a behavioural and synthesizable model of the 96x64 SSD1331-style panel interface.
- Samples sck/mosi/cs/dc from the SPI master using the system clock and assembles bytes.
- Parses the window-addressing commands, converts 16-bit pixel data into framebuffer write strobes with addresses, and flags frame completion.
- Used as the display model in game-level benches and as the front end of an optional on-chip framebuffer mirror.

Parameters:
- COLS, 96, panel width in pixels
- ROWS, 64, panel height in pixels
- SYNC_STAGES, 2, synchroniser depth on sck/mosi/cs/dc (minimum 2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sck  in  1  SPI clock (mode 0), asynchronous to clk
- mosi  in  1  serial data, MSB first
- cs  in  1  chip select, active-low
- dc  in  1  0 = command/argument byte, 1 = pixel data byte
- byte_valid  out  1  one-cycle strobe per completed byte
- byte_data  out  8  last completed byte
- byte_is_cmd  out  1  dc value latched with byte_data
- wr_en  out  1  one-cycle pixel write strobe
- wr_addr  out  13  row*COLS+col of the pixel being written
- wr_data  out  16  RGB565 pixel, first byte = [15:8]
- frame_done  out  1  one-cycle strobe when the last pixel of the window is written
- cmd_busy  out  1  high while command arguments are still expected

Behaviour:
- Reset values (async, reset=0):
  - All outputs 0.
  - col_start=0, col_end=COLS-1, row_start=0, row_end=ROWS-1, col_ptr=0, row_ptr=0.
  - Bit count 0, pixel phase 0, parser in IDLE.
- Front end:
  - sck, mosi, cs and dc each pass through SYNC_STAGES flops.
  - A rising edge means synced sck is 1 and its previous value was 0.
  - Bus timing requirement: sck high and low phases must each last at least SYNC_STAGES+1 clk cycles.
- Shifting:
  - On each rising edge with synced cs=0, shift mosi into the LSB of the shift register and increment the 3-bit bit count.
  - On the 8th bit, latch dc, and on the next clk assert byte_valid for 1 cycle with byte_data and byte_is_cmd.
  - Synced cs=1 clears the bit count; a partial byte is discarded with no strobe. Pixel phase and parser state survive cs toggling.
- Parser FSM states: IDLE, COL_A, COL_B, ROW_A, ROW_B, SKIP. Only command bytes (dc=0) advance it.
  - IDLE + 0x15 -> COL_A
  - IDLE + 0x75 -> ROW_A
  - IDLE + 0x21 -> SKIP, 7 args
  - IDLE + 0x22 -> SKIP, 10 args
  - IDLE + 0x25 -> SKIP, 4 args
  - IDLE + 0x26 -> SKIP, 1 arg
  - IDLE + any other byte -> IDLE (no-arg command)
  - COL_A: store the argument as col_start -> COL_B
  - COL_B: store the argument as col_end, set col_ptr=col_start, clear pixel phase -> IDLE
  - ROW_A / ROW_B: same pattern for row_start, row_end and row_ptr
  - SKIP: decrement the argument counter; at 0 -> IDLE
- cmd_busy = (state != IDLE).
- Argument rules:
  - Column arguments greater than COLS-1 clamp to COLS-1; row arguments greater than ROWS-1 clamp to ROWS-1.
  - If end < start after clamping, end := start.
- A data byte (dc=1) arriving while cmd_busy:
  - Aborts the command; parser -> IDLE and the partial window update is dropped.
  - The byte is then processed as pixel data.
- Pixel path:
  - Phase 0: store the byte as the high byte, phase := 1.
  - Phase 1: on the cycle after its byte_valid, assert wr_en for 1 cycle with wr_addr=row_ptr*COLS+col_ptr and wr_data={hi,byte}; phase := 0.
- Pointer advance on each write:
  - If col_ptr==col_end: col_ptr := col_start, then advance the row.
  - Otherwise col_ptr+1.
  - Row advance: if row_ptr==row_end, row_ptr := row_start and frame_done is asserted in the same cycle as wr_en; otherwise row_ptr+1.
- Latency: 8th synced rising edge detect -> byte_valid +1 clk -> wr_en +1 clk.
- wr_addr arithmetic is 13-bit and never exceeds COLS*ROWS-1 because of clamping.

Test Plan:
- Reset: reset=0 mid-byte with 5 bits shifted, then release -> all outputs 0. Next byte 0xA5 (dc=0) yields byte_valid with byte_data=0xA5 and byte_is_cmd=1.
- Full frame: 12288 data bytes 0x00,0x01 repeating -> 6144 wr_en pulses with addresses 0..6143 and wr_data=0x0001. frame_done fires only with addr 6143; the next pixel goes to addr 0.
- Window: 0x15,10,12 and 0x75,5,6 (dc=0), then 7 pixels -> addresses 490,491,492,586,587,588, then 490 again. frame_done fires on the 6th pixel.
- Clamp and abort: 0x15,200,3 -> col window 95..95. Then 0x75,7 followed by a data byte -> cmd_busy drops and the row window stays at 0..63.
- Skip: 0x22 plus 10 argument bytes including 0x15 -> no window change, cmd_busy high for exactly 10 arguments.
- cs abort: cs rises after 4 bits, then a full byte 0x3C -> no strobe for the partial byte; byte_data=0x3C.
